// File: rtl/rom_loader.sv
// Boot ROM loader: receives a length-prefixed, XOR-checksummed byte stream and
// writes big-endian words into instruction memory, holding the CPU in reset until a good image lands.
module rom_loader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_reset
);

    typedef enum logic [3:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [31:0]         MAX_WORDS = 32'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] IDX_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     idx_q, idx_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [7:0]              hi_q, hi_d;
    logic [7:0]              csum_q, csum_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    accept;
    logic [31:0]             count_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            csum_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            csum_q  <= csum_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        csum_d     = csum_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        accept     = in_valid && in_ready;
        // Full word count as it would be committed by a CNT_LO accept this cycle.
        count_full = {16'h0000, cnt_q[15:8], in_data};

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d = CNT_HI;
                    idx_d   = '0;
                    csum_d  = '0;
                end
            end
            CNT_HI: begin
                if (accept) begin
                    cnt_d   = {in_data, cnt_q[7:0]};
                    csum_d  = csum_q ^ in_data;
                    state_d = CNT_LO;
                end
            end
            CNT_LO: begin
                if (accept) begin
                    cnt_d  = {cnt_q[15:8], in_data};
                    csum_d = csum_q ^ in_data;
                    if (count_full > MAX_WORDS) begin
                        state_d = ERROR;
                    end else if (count_full == 32'd0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (accept) begin
                    hi_d    = in_data;
                    csum_d  = csum_q ^ in_data;
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                if (accept) begin
                    addr_d  = idx_q[ADDR_WIDTH-1:0];
                    wdata_d = DATA_WIDTH'({hi_q, in_data});
                    csum_d  = csum_q ^ in_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                idx_d = idx_q + IDX_ONE;
                if (32'(idx_q) + 32'd1 == {16'h0000, cnt_q}) begin
                    state_d = CHECK;
                end else begin
                    state_d = DATA_HI;
                end
            end
            CHECK: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? DONE : ERROR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == CNT_HI) || (state_q == CNT_LO) ||
                       (state_q == DATA_HI) || (state_q == DATA_LO) ||
                       (state_q == CHECK);
    assign busy      = in_ready || (state_q == WRITE);
    assign mem_we    = (state_q == WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERROR);
    assign cpu_reset = (state_q != DONE);

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: table of image streams with a write scoreboard,
// plus hand sequences for restart, mid-load reset, reset priority and the count limit.
module tb_rom_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, mem_we, busy, done, error, cpu_reset;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;

    int unsigned n_vec = 0;
    int unsigned n_fail = 0;
    int unsigned wr_seen = 0;
    logic [14:0] qa[$];
    logic [15:0] qd[$];

    typedef struct {
        logic [63:0] bytes;   // first byte in [63:56]
        int unsigned nb;
        bit          exp_done;
        int unsigned nwr;
        logic [31:0] words;   // word 0 in [31:16], word 1 in [15:0]
        bit          tog;
    } vec_t;

    vec_t vecs[7];

    rom_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cpu_reset (cpu_reset)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Write scoreboard: every mem_we pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_seen++;
            if (qa.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_write: got %0h@%0h, expected no write", mem_wdata, mem_addr);
            end else begin
                chk("wr_addr", 32'(mem_addr), 32'(qa.pop_front()));
                chk("wr_data", 32'(mem_wdata), 32'(qd.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit tog);
        bit acc = 1'b0;
        int unsigned g = 0;
        while (!acc) begin
            if (tog) begin
                @(negedge clk) in_valid = 1'b0;
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b;
            acc      = in_ready;
            g++;
            if (!acc && g > 50) begin
                chk("accept_timeout", 32'(acc), 32'd1);
                break;
            end
        end
    endtask

    task automatic end_stream();
        @(negedge clk) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned g = 0;
        while (busy && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("settle_busy", 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    endtask

    initial begin
        vecs[0] = '{64'h0002_1234_ABCD_4200, 7, 1'b1, 2, 32'h1234_ABCD, 1'b0};
        vecs[1] = '{64'h0002_1234_ABCD_4200, 7, 1'b1, 2, 32'h1234_ABCD, 1'b1};
        vecs[2] = '{64'h0000_0000_0000_0000, 3, 1'b1, 0, 32'h0000_0000, 1'b0};
        vecs[3] = '{64'h0000_0100_0000_0000, 3, 1'b0, 0, 32'h0000_0000, 1'b0};
        vecs[4] = '{64'h0001_FFFF_0000_0000, 5, 1'b0, 1, 32'hFFFF_0000, 1'b0};
        vecs[5] = '{64'h8001_0000_0000_0000, 2, 1'b0, 0, 32'h0000_0000, 1'b0};
        vecs[6] = '{64'h0001_0007_0600_0000, 5, 1'b1, 1, 32'h0007_0000, 1'b0};

        repeat (3) @(negedge clk);
        chk_reset_vals("rst_init");
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("idle");

        for (int i = 0; i < 7; i++) begin
            wr_seen = 0;
            for (int unsigned w = 0; w < vecs[i].nwr; w++) begin
                qa.push_back(15'(w));
                qd.push_back(vecs[i].words[31 - 16*w -: 16]);
            end
            do_start();
            chk("start_busy", 32'(busy), 32'd1);
            for (int unsigned k = 0; k < vecs[i].nb; k++) begin
                send_byte(vecs[i].bytes[63 - 8*k -: 8], vecs[i].tog);
            end
            end_stream();
            wait_idle();
            chk("done", 32'(done), 32'(vecs[i].exp_done));
            chk("error", 32'(error), 32'(!vecs[i].exp_done));
            chk("cpu_reset", 32'(cpu_reset), 32'(!vecs[i].exp_done));
            chk("nwrites", wr_seen, vecs[i].nwr);
            chk("pending", 32'(qa.size()), 32'd0);
            if (i == 5) begin
                in_valid = 1'b1;
                in_data  = 8'h00;
                repeat (3) begin
                    @(negedge clk);
                    chk("err_in_ready", 32'(in_ready), 32'd0);
                end
                in_valid = 1'b0;
                chk("err_hold", 32'(error), 32'd1);
            end
        end

        // start during DATA_LO is ignored
        wr_seen = 0;
        qa.push_back(15'h0000); qd.push_back(16'h1234);
        qa.push_back(15'h0001); qd.push_back(16'hABCD);
        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("dlo_start_ignored", 32'(in_ready), 32'd1);
        send_byte(8'h34, 1'b0);
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        send_byte(8'h42, 1'b0);
        end_stream();
        wait_idle();
        chk("dlo_done", 32'(done), 32'd1);
        chk("dlo_nwrites", wr_seen, 32'd2);
        chk("dlo_cpu_reset", 32'(cpu_reset), 32'd0);

        // restart from DONE
        do_start();
        chk("restart_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_done", 32'(done), 32'd0);

        // reset after third accepted byte
        wr_seen = 0;
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h34;
        @(negedge clk);
        chk_reset_vals("midload_rst");
        reset = 1'b0;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd0);
        chk("post_rst_nwrites", wr_seen, 32'd0);

        // reset beats start in the same cycle
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_prio_busy", 32'(busy), 32'd0);
        chk("rst_prio_cpu_reset", 32'(cpu_reset), 32'd1);

        // N = 2^ADDR_WIDTH is accepted as a count
        do_start();
        send_byte(8'h80, 1'b0);
        send_byte(8'h00, 1'b0);
        end_stream();
        chk("max_n_error", 32'(error), 32'd0);
        chk("max_n_busy", 32'(busy), 32'd1);
        chk("max_n_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("max_n_rst_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 15, instruction memory address width (2^ADDR_WIDTH words).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-006 SHALL have port in_valid  input  1  byte stream valid.
REQ-007 SHALL have port in_data  input  8  byte stream data.
REQ-008 SHALL have port in_ready  output  1  loader can accept a byte this cycle.
REQ-009 SHALL have port mem_we  output  1  instruction memory write enable, one cycle per word.
REQ-010 SHALL have port mem_addr  output  ADDR_WIDTH  write address.
REQ-011 SHALL have port mem_wdata  output  DATA_WIDTH  write data.
REQ-012 SHALL have port busy  output  1  load in progress.
REQ-013 SHALL have port done  output  1  last load completed with valid checksum.
REQ-014 SHALL have port error  output  1  last load failed (bad count or checksum).
REQ-015 SHALL have port cpu_reset  output  1  holds the CPU in reset while no valid image is loaded.

Function
REQ-016 SHALL accept a byte only on a cycle with in_valid=1 and in_ready=1; in_valid without in_ready has no effect.
REQ-017 SHALL implement states IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR.
REQ-018 SHALL assert in_ready exactly in CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK.
REQ-019 SHALL move IDLE, DONE or ERROR -> CNT_HI on start=1; start in any other state is ignored.
REQ-020 SHALL, on entry to CNT_HI, clear the word index to 0 and the running XOR checksum to 0x00.
REQ-021 SHALL take the image word count N as 16 bits, big-endian: CNT_HI byte = N[15:8], CNT_LO byte = N[7:0].
REQ-022 SHALL, on the CNT_LO accept, go to ERROR if N > 2^ADDR_WIDTH, to CHECK if N = 0, else to DATA_HI.
REQ-023 SHALL assemble each word big-endian: DATA_HI byte -> word[15:8], DATA_LO byte -> word[7:0], then go to WRITE.
REQ-024 SHALL, in WRITE, drive mem_we=1 for exactly one cycle with mem_addr = word index and mem_wdata = assembled word, then increment index; go to CHECK if index+1 = N, else DATA_HI.
REQ-025 SHALL update the running checksum as XOR of every accepted byte in CNT_HI, CNT_LO, DATA_HI, DATA_LO.
REQ-026 SHALL, on the CHECK accept, go to DONE if the byte equals the running checksum, else to ERROR.
REQ-027 SHALL drive mem_addr and mem_wdata from registers; values outside WRITE are don't-care but stable.
REQ-028 SHALL drive busy=1 in CNT_HI through CHECK, done=1 only in DONE, error=1 only in ERROR.
REQ-029 SHALL drive cpu_reset=0 only in DONE; a restart from DONE re-asserts cpu_reset the next cycle.
REQ-030 SHALL hold index width ADDR_WIDTH+1 bits so N = 2^ADDR_WIDTH completes without wrap; final write address = 2^ADDR_WIDTH-1.
REQ-031 SHALL sustain one word per 3 cycles minimum (DATA_HI, DATA_LO, WRITE) with in_valid held high.

Reset
REQ-032 SHALL, on reset=1 in any state including mid-load, enter IDLE next edge with in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, cpu_reset=1, index=0, checksum=0x00.
REQ-033 SHALL give reset priority over start and in_valid in the same cycle.

Verification
REQ-034 SHALL pass: start, bytes 00 02 12 34 AB CD 42 -> writes 0x1234@0, 0xABCD@1, exactly 2 mem_we pulses, done=1, cpu_reset=0.
REQ-035 SHALL pass: start, bytes 00 00 00 -> no mem_we, done=1; bytes 00 00 01 instead -> error=1, cpu_reset=1.
REQ-036 SHALL pass: start, bytes 00 01 FF FF 00 -> one write 0xFFFF@0, then error=1 (expected check 0x01), cpu_reset=1.
REQ-037 SHALL pass: start, bytes 80 01 -> ERROR after second byte, no mem_we, in_ready=0 thereafter until start.
REQ-038 SHALL pass: REQ-034 stream with in_valid toggling every cycle -> identical writes and done; reset after third accepted byte -> all outputs at REQ-032 values, IDLE, no further writes.
REQ-039 SHALL pass: start during DATA_LO of a load -> ignored, load completes per REQ-034; start in DONE -> cpu_reset=1, busy=1 next cycle.
